// File: rtl/dut_resp_cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dut_resp_cmp_pkg
//  Description : Shared defaults, FSM state encoding and helpers for the
//                DUT response comparator.
//  Revision    : 1.0  initial release
// ============================================================================
package dut_resp_cmp_pkg;

  // Default pin count and counter width
  localparam int WIDTH_DEF = 126;
  localparam int CNT_W_DEF = 16;

  // Test sequencer state encoding
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Cycle lengths 0 and 1 both mean a one-clock test cycle
  function automatic logic [7:0] eff_len(input logic [7:0] len);
    return (len <= 8'd1) ? 8'd1 : len;
  endfunction

endpackage : dut_resp_cmp_pkg
`default_nettype wire

// File: rtl/dut_resp_cmp_if.sv
`default_nettype none
// ============================================================================
//  Module      : dut_resp_cmp_if
//  Description : Control, data and status bundle of the DUT response
//                comparator. The master drives test setup, buffer loads and
//                DUT pins; the slave (comparator) returns results.
//  Revision    : 1.0  initial release
// ============================================================================
interface dut_resp_cmp_if
  import dut_resp_cmp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic             PERFORM_TEST;
  logic [CNT_W-1:0] NUM_CYCLES;
  logic [7:0]       CYCLE_LENGTH_1;
  logic [6:0]       STROBE_1;
  logic [WIDTH-1:0] BUS126;
  logic             EXP_LOAD;
  logic             EXP_TRANSFER;
  logic             MASK_LOAD;
  logic             MASK_TRANSFER;
  logic [WIDTH-1:0] DUT_IN;
  logic             CMP_VALID;
  logic [WIDTH-1:0] FAIL_VEC;
  logic [WIDTH-1:0] FAIL_STICKY;
  logic [CNT_W-1:0] ERR_COUNT;
  logic             BUSY;
  logic             DONE;
  logic             PASS;

  modport master (
    output PERFORM_TEST, NUM_CYCLES, CYCLE_LENGTH_1, STROBE_1, BUS126,
           EXP_LOAD, EXP_TRANSFER, MASK_LOAD, MASK_TRANSFER, DUT_IN,
    input  CMP_VALID, FAIL_VEC, FAIL_STICKY, ERR_COUNT, BUSY, DONE, PASS
  );

  modport slave (
    input  PERFORM_TEST, NUM_CYCLES, CYCLE_LENGTH_1, STROBE_1, BUS126,
           EXP_LOAD, EXP_TRANSFER, MASK_LOAD, MASK_TRANSFER, DUT_IN,
    output CMP_VALID, FAIL_VEC, FAIL_STICKY, ERR_COUNT, BUSY, DONE, PASS
  );

endinterface : dut_resp_cmp_if
`default_nettype wire

// File: rtl/dut_resp_db_reg.sv
`default_nettype none
// ============================================================================
//  Module      : dut_resp_db_reg
//  Description : Double-buffered register: LOAD writes the pre-buffer,
//                TRANSFER copies pre-buffer to active. When both pulse in the
//                same clock the old pre-buffer value is transferred while the
//                new data lands in the pre-buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module dut_resp_db_reg
  import dut_resp_cmp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             transfer_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] pre_o,
  output logic [WIDTH-1:0] active_o
);

  logic [WIDTH-1:0] pre_q;
  logic [WIDTH-1:0] active_q;

  // Pre-buffer load and transfer to active; non-blocking semantics give the
  // old-value transfer on a simultaneous load
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q    <= '0;
      active_q <= '0;
    end else begin
      if (load_i)     pre_q    <= data_i;
      if (transfer_i) active_q <= pre_q;
    end
  end

  assign pre_o    = pre_q;
  assign active_o = active_q;

endmodule : dut_resp_db_reg
`default_nettype wire

// File: rtl/dut_resp_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : dut_resp_cmp
//  Description : DUT response comparator. Runs NUM_CYCLES test cycles of
//                CYCLE_LENGTH_1 clocks, samples DUT_IN at tick STROBE_1 and
//                compares it against the active expected data under the
//                active mask, accumulating per-pin and per-cycle results.
//  Options     : DUT_RESP_SYNC_EN - 2-flop synchronizer on DUT_IN
//  Revision    : 1.0  initial release
// ============================================================================
module dut_resp_cmp
  import dut_resp_cmp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  dut_resp_cmp_if.slave bus
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [7:0]       tick_q, tick_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             pt_q;
  logic [WIDTH-1:0] cap_q;
  logic             cmp_pend_q;
  logic             cmp_valid_q;
  logic [WIDTH-1:0] fail_vec_q;
  logic [WIDTH-1:0] sticky_q;
  logic [CNT_W-1:0] err_q;

  logic [WIDTH-1:0] w_exp_act;
  logic [WIDTH-1:0] w_mask_act;
  logic [WIDTH-1:0] w_exp_pre;
  logic [WIDTH-1:0] w_mask_pre;
  logic [WIDTH-1:0] w_dut;
  logic [7:0]       w_len;
  logic [7:0]       w_strobe;
  logic [CNT_W-1:0] w_cyc_inc;
  logic             w_pt_rise;
  logic             w_last_tick;
  logic             w_capture;
  logic             w_start;

  // Expected-data and mask double buffers
  dut_resp_db_reg #(.WIDTH(WIDTH)) u_exp_buf (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .load_i     (bus.EXP_LOAD),
    .transfer_i (bus.EXP_TRANSFER),
    .data_i     (bus.BUS126),
    .pre_o      (w_exp_pre),
    .active_o   (w_exp_act)
  );

  dut_resp_db_reg #(.WIDTH(WIDTH)) u_mask_buf (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .load_i     (bus.MASK_LOAD),
    .transfer_i (bus.MASK_TRANSFER),
    .data_i     (bus.BUS126),
    .pre_o      (w_mask_pre),
    .active_o   (w_mask_act)
  );

`ifdef DUT_RESP_SYNC_EN
  logic [WIDTH-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer in front of the capture register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.DUT_IN;
      sync2_q <= sync1_q;
    end
  end

  assign w_dut = sync2_q;
`else
  assign w_dut = bus.DUT_IN;
`endif

  assign w_pt_rise   = bus.PERFORM_TEST & ~pt_q;
  assign w_len       = eff_len(bus.CYCLE_LENGTH_1);
  assign w_strobe    = {1'b0, bus.STROBE_1};
  assign w_last_tick = (tick_q == (w_len - 8'd1));
  assign w_cyc_inc   = cyc_q + C_CNT_ONE;

  // A strobe beyond the cycle end never matches, so that cycle has no sample
  assign w_capture = (state_q == ST_RUN) && bus.PERFORM_TEST &&
                     (bus.NUM_CYCLES != '0) && (w_strobe < w_len) &&
                     (tick_q == w_strobe);

  // Next-state logic for the sequencer and its tick/cycle counters
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    cyc_d   = cyc_q;
    w_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_pt_rise) begin
          state_d = ST_RUN;
          tick_d  = '0;
          cyc_d   = '0;
          w_start = 1'b1;
        end
      end
      ST_RUN: begin
        if (!bus.PERFORM_TEST) begin
          state_d = ST_IDLE;
        end else if (bus.NUM_CYCLES == '0) begin
          state_d = ST_DONE;
        end else if (w_last_tick) begin
          tick_d = '0;
          cyc_d  = w_cyc_inc;
          if (w_cyc_inc == bus.NUM_CYCLES) state_d = ST_DONE;
        end else begin
          tick_d = tick_q + 8'd1;
        end
      end
      ST_DONE: begin
        if (!bus.PERFORM_TEST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers; edge history resets high so a PERFORM_TEST still
  // held high across reset does not count as a fresh start
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      cyc_q   <= '0;
      pt_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      cyc_q   <= cyc_d;
      pt_q    <= bus.PERFORM_TEST;
    end
  end

  // Capture the masked difference at the strobe edge, using the active
  // buffers as they were before this edge
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cap_q      <= '0;
      cmp_pend_q <= 1'b0;
    end else begin
      cmp_pend_q <= w_capture;
      if (w_capture) cap_q <= (w_dut ^ w_exp_act) & w_mask_act;
    end
  end

  // Publish the compare result and accumulate sticky/error statistics
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cmp_valid_q <= 1'b0;
      fail_vec_q  <= '0;
      sticky_q    <= '0;
      err_q       <= '0;
    end else begin
      cmp_valid_q <= cmp_pend_q;
      if (cmp_pend_q) fail_vec_q <= cap_q;
      if (w_start) begin
        sticky_q <= '0;
        err_q    <= '0;
      end else if (cmp_pend_q) begin
        sticky_q <= sticky_q | cap_q;
        if ((|cap_q) && !(&err_q)) err_q <= err_q + C_CNT_ONE;
      end
    end
  end

  assign bus.CMP_VALID   = cmp_valid_q;
  assign bus.FAIL_VEC    = fail_vec_q;
  assign bus.FAIL_STICKY = sticky_q;
  assign bus.ERR_COUNT   = err_q;
  assign bus.BUSY        = (state_q == ST_RUN);
  assign bus.DONE        = (state_q == ST_DONE);
  assign bus.PASS        = (state_q == ST_DONE) && (err_q == '0);

endmodule : dut_resp_cmp
`default_nettype wire
